gat_bram_host_bridge: RTL
=========================

Name: gat_bram_host_bridge

Overview:
- Parametrised host-side BRAM access bridge between the PS/AXI BRAM controllers and the GAT core.
- Converts byte addresses to word addresses and steers host writes to one of NUM_CH core BRAM load ports.
- Counts accepted writes per channel against a programmed expected count and raises per-channel load-done flags.
- Serves pipelined host read-back from NUM_CH core result ports with a matched valid strobe.

Parameters:
- NUM_CH, 3: number of core BRAM channels (h_data, node_info, weight); 1..8.
- DATA_W, 32: word width on host and core data buses.
- ADDR_W, 18: core word-address width.
- BYTE_OFS, 2: byte-offset bits dropped from host addresses.
- CNT_W, 18: width of the expected/accepted write counters.
- CORE_RD_LAT, 2: core BRAM read latency in cycles, ≥1.
- CH_W, $clog2(NUM_CH) (minimum 1): channel-select width.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset. Asynchronous assert, active-low.
- cfg_start, in, 1: one-cycle pulse; arms a new load.
- cfg_expect, in, NUM_CH*CNT_W: expected word count per channel; channel i occupies bits [i*CNT_W +: CNT_W]. Sampled on cfg_start.
- host_ena, in, 1: host port enable.
- host_wea, in, 1: host write enable.
- host_ch, in, CH_W: write target channel.
- host_addr, in, ADDR_W+BYTE_OFS: host byte address.
- host_din, in, DATA_W: host write data.
- bram_ena, out, NUM_CH: per-channel core write enable.
- bram_wea, out, NUM_CH: per-channel core write strobe.
- bram_addra, out, ADDR_W: shared core word address.
- bram_din, out, DATA_W: shared core write data.
- load_done, out, NUM_CH: sticky per-channel done flags.
- all_loaded, out, 1: level; asserted in state DONE.
- wr_overflow, out, 1: sticky; a write arrived for an already-full channel.
- wr_unaligned, out, 1: sticky; a write arrived with nonzero byte-offset bits.
- host_rd_en, in, 1: host read request.
- host_rd_ch, in, CH_W: read source channel.
- host_rd_addr, in, ADDR_W+BYTE_OFS: host read byte address.
- core_rd_addr, out, ADDR_W: read word address driven to all channels.
- core_rd_data, in, NUM_CH*DATA_W: per-channel core read data.
- host_rd_data, out, DATA_W: read-back data.
- host_rd_valid, out, 1: one-cycle strobe qualifying host_rd_data.
- dbg_drop_cnt, out, 32: dropped-write counter (optional feature).

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Counters and read pipeline cleared.
  - Reset mid-load discards all progress.
- Address translation: word address = host_addr[ADDR_W+BYTE_OFS-1:BYTE_OFS]; low BYTE_OFS bits are ignored for addressing.
- State machine:
  - IDLE: on cfg_start -> LOAD.
  - LOAD: on all channels done -> DONE.
  - DONE: on cfg_start -> LOAD.
  - cfg_start in any state:
    - loads expect_q from cfg_expect;
    - clears cnt, load_done, wr_overflow and wr_unaligned;
    - enters LOAD.
  - A write on the same cycle as cfg_start is dropped.
- Accepted write: host_ena & host_wea & state==LOAD & host_ch<NUM_CH & cnt[host_ch]<expect_q[host_ch].
  - Registered one cycle later as bram_ena/bram_wea one-hot on host_ch, with bram_addra and bram_din.
  - cnt[host_ch] increments on acceptance.
- Unaligned writes are still accepted; they set wr_unaligned.
- Dropped writes:
  - Write to a full channel: dropped, sets wr_overflow.
  - host_ch≥NUM_CH: dropped, no flag.
  - Write outside LOAD: dropped, no flag.
  - Dropped writes produce no bram_ena.
- load_done[i] rises the cycle after cnt[i] reaches expect_q[i].
  - A channel with expect 0 is done the cycle after cfg_start.
  - All channels 0: DONE two cycles after cfg_start.
- all_loaded rises the cycle after the last load_done; LOAD->DONE happens on that same edge.
- Read path (independent of state, legal concurrently with writes):
  - core_rd_addr is registered from host_rd_addr (word-translated) when host_rd_en.
  - host_rd_en and host_rd_ch are delayed CORE_RD_LAT+1 cycles in a shift pipeline.
  - host_rd_valid and host_rd_data (core_rd_data slice for the delayed channel) are registered at that point.
  - Total latency: CORE_RD_LAT+2 cycles from host_rd_en to host_rd_valid.
  - Back-to-back reads are fully pipelined, one per cycle.
  - host_rd_ch≥NUM_CH returns data 0 with valid asserted.
- Counters saturate at expect_q; no wrap.

Optional Feature:
- GAT_BRIDGE_DEBUG_EN defined: dbg_drop_cnt increments on every dropped write (any reason, including the cfg_start collision).
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset only, not by cfg_start.
- GAT_BRIDGE_DEBUG_EN undefined: dbg_drop_cnt tied to 0 and no counter logic is built.

Decomposition:
- Shared package gat_bridge_pkg holds:
  - state enum {IDLE, LOAD, DONE};
  - BYTE_OFS default;
  - helper function for the expect-slice index.
- Sub-module gat_bridge_rd_pipe: the read delay line, parametrised by depth CORE_RD_LAT+1 and payload width CH_W+1.

Test Plan:
- Basic load: expect={4,2,3}, cfg_start, then 9 aligned writes interleaved across channels -> each write appears on bram_* one cycle later with bram_addra=host_addr>>2; load_done bits rise individually; all_loaded=1 after the ninth write.
- Overflow: expect ch0=2, three writes to ch0 -> only two bram_ena pulses; wr_overflow=1; with GAT_BRIDGE_DEBUG_EN, dbg_drop_cnt=1.
- Unaligned and out-of-range: write host_addr=0x0006 to ch1 -> accepted at word 1, wr_unaligned=1; write with host_ch=3 -> no bram_ena, no flags set.
- Zero expect: cfg_expect all 0, cfg_start -> load_done=3'b111 one cycle later, all_loaded two cycles later.
- Read pipeline: CORE_RD_LAT=2, reads to ch2 at byte addrs 0x10,0x14,0x18 on consecutive cycles -> core_rd_addr 4,5,6; three consecutive host_rd_valid pulses starting 4 cycles after the first host_rd_en, returning ch2 data.
- Reset mid-load: deassert rst_n after 2 of 4 writes -> all outputs 0, state IDLE; subsequent writes without cfg_start are dropped.

Source files
------------

// File: rtl/gat_bridge_pkg.sv
// Shared definitions for the GAT host BRAM bridge: load FSM states,
// default byte-offset width and the expect-vector slice helper.
package gat_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BYTE_OFS_DEF = 2;

    // LSB position of channel ch inside a packed per-channel counter vector
    function automatic int exp_lsb(input int ch, input int cnt_w);
        return ch * cnt_w;
    endfunction

endpackage

// File: rtl/gat_bridge_rd_pipe.sv
// Read-request delay line: carries {valid, channel} through DEPTH
// register stages so the read-back mux lines up with core BRAM latency.
module gat_bridge_rd_pipe
    import gat_bridge_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] data_p [DEPTH];

    // Shift the request payload one stage per clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) data_p[i] <= '0;
        end else begin
            data_p[0] <= din;
            for (int i = 1; i < DEPTH; i++) data_p[i] <= data_p[i-1];
        end
    end

    assign dout = data_p[DEPTH-1];

endmodule

// File: rtl/gat_bram_host_bridge.sv
// Host-side BRAM access bridge for the GAT core. Steers host writes to
// one of NUM_CH core load ports, tracks per-channel load progress and
// serves pipelined read-back from the core result ports.
// Optional build macro: GAT_BRIDGE_DEBUG_EN enables the dropped-write
// counter on dbg_drop_cnt (tied to 0 otherwise).
module gat_bram_host_bridge
    import gat_bridge_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 18,
    parameter int BYTE_OFS    = BYTE_OFS_DEF,
    parameter int CNT_W       = 18,
    parameter int CORE_RD_LAT = 2,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_start,
    input  logic [NUM_CH*CNT_W-1:0]    cfg_expect,
    input  logic                       host_ena,
    input  logic                       host_wea,
    input  logic [CH_W-1:0]            host_ch,
    input  logic [ADDR_W+BYTE_OFS-1:0] host_addr,
    input  logic [DATA_W-1:0]          host_din,
    output logic [NUM_CH-1:0]          bram_ena,
    output logic [NUM_CH-1:0]          bram_wea,
    output logic [ADDR_W-1:0]          bram_addra,
    output logic [DATA_W-1:0]          bram_din,
    output logic [NUM_CH-1:0]          load_done,
    output logic                       all_loaded,
    output logic                       wr_overflow,
    output logic                       wr_unaligned,
    input  logic                       host_rd_en,
    input  logic [CH_W-1:0]            host_rd_ch,
    input  logic [ADDR_W+BYTE_OFS-1:0] host_rd_addr,
    output logic [ADDR_W-1:0]          core_rd_addr,
    input  logic [NUM_CH*DATA_W-1:0]   core_rd_data,
    output logic [DATA_W-1:0]          host_rd_data,
    output logic                       host_rd_valid,
    output logic [31:0]                dbg_drop_cnt
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q    [NUM_CH];
    logic [CNT_W-1:0]   expect_q [NUM_CH];
    logic [CNT_W-1:0]   sel_cnt, sel_exp;
    logic [NUM_CH-1:0]  ch_onehot;
    logic               wr_req, in_load, ch_ok, has_room;
    logic               accept, ovf_hit, una_hit;
    logic [ADDR_W-1:0]  wr_word, rd_word;
    logic               unused_rd_ofs;

    logic [CH_W:0]      rd_pipe_in, rd_pipe_out;
    logic               rd_vld_p;
    logic [CH_W-1:0]    rd_ch_p;
    logic [DATA_W-1:0]  rd_sel;

    assign wr_word       = host_addr[ADDR_W+BYTE_OFS-1:BYTE_OFS];
    assign rd_word       = host_rd_addr[ADDR_W+BYTE_OFS-1:BYTE_OFS];
    assign unused_rd_ofs = ^host_rd_addr[BYTE_OFS-1:0];

    // Decode the write target channel and pick its counter/limit
    always_comb begin
        sel_cnt   = '0;
        sel_exp   = '0;
        ch_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (host_ch == CH_W'(i)) begin
                sel_cnt      = cnt_q[i];
                sel_exp      = expect_q[i];
                ch_onehot[i] = 1'b1;
            end
        end
    end

    // A cfg_start cycle re-arms the load, so any write alongside it is dropped
    assign wr_req   = host_ena & host_wea;
    assign in_load  = (state_q == LOAD) && !cfg_start;
    assign ch_ok    = |ch_onehot;
    assign has_room = sel_cnt < sel_exp;
    assign accept   = wr_req & in_load & ch_ok & has_room;
    assign ovf_hit  = wr_req & in_load & ch_ok & ~has_room;
    assign una_hit  = accept & (host_addr[BYTE_OFS-1:0] != '0);

    // Load FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Load FSM next-state: cfg_start re-arms from any state
    always_comb begin
        state_d = state_q;
        if (cfg_start) begin
            state_d = LOAD;
        end else begin
            unique case (state_q)
                LOAD:    if (&load_done) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    assign all_loaded = (state_q == DONE);

    // Per-channel limits, accepted-write counters and sticky done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= '0;
                expect_q[i] <= '0;
            end
            load_done <= '0;
        end else if (cfg_start) begin
            for (int i = 0; i < NUM_CH; i++) begin
                expect_q[i]  <= cfg_expect[exp_lsb(i, CNT_W) +: CNT_W];
                cnt_q[i]     <= '0;
                load_done[i] <= (cfg_expect[exp_lsb(i, CNT_W) +: CNT_W] == '0);
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept && ch_onehot[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
                if (state_q == LOAD && cnt_q[i] >= expect_q[i]) load_done[i] <= 1'b1;
            end
        end
    end

    // Sticky error flags, cleared when a new load is armed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_overflow  <= 1'b0;
            wr_unaligned <= 1'b0;
        end else if (cfg_start) begin
            wr_overflow  <= 1'b0;
            wr_unaligned <= 1'b0;
        end else begin
            if (ovf_hit) wr_overflow  <= 1'b1;
            if (una_hit) wr_unaligned <= 1'b1;
        end
    end

    // Register accepted writes onto the core load ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_ena   <= '0;
            bram_wea   <= '0;
            bram_addra <= '0;
            bram_din   <= '0;
        end else begin
            bram_ena <= accept ? ch_onehot : '0;
            bram_wea <= accept ? ch_onehot : '0;
            if (accept) begin
                bram_addra <= wr_word;
                bram_din   <= host_din;
            end
        end
    end

    // Launch the read address to all core channels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          core_rd_addr <= '0;
        else if (host_rd_en) core_rd_addr <= rd_word;
    end

    assign rd_pipe_in = {host_rd_en, host_rd_ch};

    gat_bridge_rd_pipe #(
        .DEPTH (CORE_RD_LAT + 1),
        .WIDTH (CH_W + 1)
    ) u_rd_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rd_pipe_in),
        .dout  (rd_pipe_out)
    );

    assign rd_vld_p = rd_pipe_out[CH_W];
    assign rd_ch_p  = rd_pipe_out[CH_W-1:0];

    // Pick the returning channel's data; out-of-range channels read as 0
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch_p == CH_W'(i)) rd_sel = core_rd_data[i*DATA_W +: DATA_W];
        end
    end

    // Capture read-back data with its matching valid strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rd_valid <= 1'b0;
            host_rd_data  <= '0;
        end else begin
            host_rd_valid <= rd_vld_p;
            if (rd_vld_p) host_rd_data <= rd_sel;
        end
    end

`ifdef GAT_BRIDGE_DEBUG_EN
    logic        drop;
    logic [31:0] drop_cnt_q;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign drop = wr_req & ~accept;

    // Count every dropped write attempt, saturating; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    drop_cnt_q <= '0;
        else if (drop) drop_cnt_q <= sat_inc32(drop_cnt_q);
    end

    assign dbg_drop_cnt = drop_cnt_q;
`else
    assign dbg_drop_cnt = '0;
`endif

endmodule
